gpio_dbus_slave: RTL
====================

# gpio_dbus_slave

General-purpose I/O peripheral attached as a slave on the data bus, downstream of the dbus address decoder. Consumes the decoded peripheral request (`type_dbus2peri_s` plus a dedicated select line) and returns read data and a one-cycle acknowledge on `type_peri2dbus_s`. Provides per-pin output data, direction control, a two-flop input synchronizer, and optional edge-triggered interrupts toward the PLIC.

## Interface
- `GPIO_WIDTH`, 16, number of GPIO pins, 1..32; register bits at or above `GPIO_WIDTH` read 0 and ignore writes.
- `rst_n`  input  1  asynchronous active-low reset.
- `clk`  input  1  single clock; all state in this domain.
- `dbus2peri_i`  input  `type_dbus2peri_s`  addr, w_data, sel_byte, req, w_en from the dbus decoder.
- `gpio_sel_i`  input  1  GPIO select from the address decoder.
- `gpio2dbus_o`  output  `type_peri2dbus_s`  r_data and ack back to the dbus read mux.
- `gpio_in_i`  input  `GPIO_WIDTH`  asynchronous pad inputs.
- `gpio_out_o`  output  `GPIO_WIDTH`  output data register.
- `gpio_oe_o`  output  `GPIO_WIDTH`  output enable (1 = drive).
- `gpio_irq_o`  output  1  level interrupt to the PLIC.

## Operation
- Register map, decoded on `addr[4:2]`, byte offsets:
  - 0x00 DATA_IN (RO): synchronized inputs.
  - 0x04 DATA_OUT (RW).
  - 0x08 DIR (RW).
  - 0x0C IRQ_EN (RW).
  - 0x10 IRQ_POL (RW): 1 = rising edge, 0 = falling edge.
  - 0x14 IRQ_STATUS (R/W1C).
  - Offsets 0x18 and 0x1C read 0; writes to them are ignored. `addr[1:0]` is ignored.
- Access FSM, two states:
  - IDLE: if `req & gpio_sel_i`, latch addr, w_en, w_data, and sel_byte, then go to ACK.
  - ACK: `ack=1` for exactly one cycle and `r_data` valid, then return to IDLE unconditionally.
  - A request held high across ACK is accepted again in the following IDLE cycle. Maximum rate is one access per 2 cycles.
- Writes honor `sel_byte` per byte lane and commit on the clock edge that enters ACK.
- Read data is registered and presented during ACK. Unselected or write cycles drive `r_data=0`.
- Input path:
  - 2-flop synchronizer `sync1 -> sync2`, plus one delayed copy `sync3` for edge detection.
  - DATA_IN = `sync2`.
  - Edge event per pin: rising = `sync2 & ~sync3`; falling = `~sync2 & sync3`. The edge used is selected by IRQ_POL.
- IRQ_STATUS bit sets on an edge event when the corresponding IRQ_EN bit is 1, independent of DIR.
- W1C and a set event on the same bit in the same cycle: set wins, bit stays 1.
- `gpio_irq_o` = registered `|(IRQ_STATUS & IRQ_EN)`.

## Timing
- Reset values: all registers 0, so `gpio_out_o=0`, `gpio_oe_o=0`, `gpio_irq_o=0`, `ack=0`, `r_data=0`, FSM in IDLE, synchronizer flops 0.
- Reset is asynchronous. Asserting it mid-access aborts the access, clears `ack` immediately, and loses the pending write if its commit edge has not occurred.
- Access latency: request at cycle N, ack/data at cycle N+1.
- Write visibility: `gpio_out_o`/`gpio_oe_o` change at the start of N+1.
- Pin to DATA_IN: 2 clock cycles.
- Pin edge to IRQ_STATUS set: 3 cycles.
- IRQ_STATUS set to `gpio_irq_o` high: 1 cycle.
- W1C write at N: `gpio_irq_o` deasserts at N+2, unless a new edge arrived in the meantime.

## Configuration
- `GPIO_IRQ_EN` defined: IRQ_EN, IRQ_POL, and IRQ_STATUS registers, edge detection, and `gpio_irq_o` are implemented as described.
- `GPIO_IRQ_EN` undefined:
  - `sync3` and all IRQ registers are removed.
  - Offsets 0x0C–0x14 read 0 and ignore writes.
  - `gpio_irq_o` is tied to 0.
  - Port list is unchanged.

## Test plan
- Reset check: assert `rst_n=0` mid-ACK -> `ack=0` at once, all outputs 0, FSM in IDLE after release.
- Write/readback: write 0x0000A5A5 to 0x04 with `sel_byte=4'b0001` -> DATA_OUT=0x00A5 at N+1. Write again with `sel_byte=4'b1111` -> readback returns 0x0000A5A5 with `ack` high for exactly one cycle.
- Direction/width: write 0xFFFFFFFF to DIR with `GPIO_WIDTH=16` -> `gpio_oe_o=0xFFFF`, readback 0x0000FFFF.
- Input sync: toggle `gpio_in_i[3]` 0->1 -> DATA_IN bit 3 reads 1 no earlier than 2 cycles after the change.
- Interrupt: IRQ_EN=0x8, IRQ_POL=0x8, rising edge on pin 3 -> IRQ_STATUS=0x8 and `gpio_irq_o=1` one cycle later. W1C with 0x8 -> `gpio_irq_o=0`. Repeat with a same-cycle edge and W1C -> status stays 0x8.
- Back-to-back: hold `req` and `gpio_sel_i` high for 6 cycles -> exactly 3 acks, on alternate cycles. Request with `gpio_sel_i=0` -> no ack and no register change.

Source files
------------

// File: rtl/gpio_dbus_slave.sv
// GPIO slave on the data bus: output data, direction, two-flop input synchronizer.
// Define GPIO_IRQ_EN to add edge-triggered interrupts (IRQ_EN/IRQ_POL/IRQ_STATUS, gpio_irq_o).

package gpio_dbus_pkg;
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] w_data;
    logic [3:0]  sel_byte;
    logic        req;
    logic        w_en;
  } type_dbus2peri_s;

  typedef struct packed {
    logic [31:0] r_data;
    logic        ack;
  } type_peri2dbus_s;
endpackage

// state  | meaning
// S_IDLE | waiting for req & gpio_sel_i; write commits on the edge leaving here
// S_ACK  | ack high for one cycle with registered r_data
module gpio_dbus_slave
  import gpio_dbus_pkg::*;
#(
  parameter int GPIO_WIDTH = 16
) (
  input  logic                  rst_n,
  input  logic                  clk,
  input  type_dbus2peri_s       dbus2peri_i,
  input  logic                  gpio_sel_i,
  output type_peri2dbus_s       gpio2dbus_o,
  input  logic [GPIO_WIDTH-1:0] gpio_in_i,
  output logic [GPIO_WIDTH-1:0] gpio_out_o,
  output logic [GPIO_WIDTH-1:0] gpio_oe_o,
  output logic                  gpio_irq_o
);

  typedef enum logic {S_IDLE, S_ACK} state_e;

  localparam logic [2:0] A_DATA_IN    = 3'd0;
  localparam logic [2:0] A_DATA_OUT   = 3'd1;
  localparam logic [2:0] A_DIR        = 3'd2;
  localparam logic [2:0] A_IRQ_EN     = 3'd3;
  localparam logic [2:0] A_IRQ_POL    = 3'd4;
  localparam logic [2:0] A_IRQ_STATUS = 3'd5;

  state_e                state;
  logic [GPIO_WIDTH-1:0] sync1, sync2;
  logic [GPIO_WIDTH-1:0] wr_mask, wr_val;
  logic                  acc, wr;
  logic [2:0]            idx;
  logic [31:0]           rd_val;
  logic                  unused_bits;

`ifdef GPIO_IRQ_EN
  logic [GPIO_WIDTH-1:0] sync3, irq_en, irq_pol, irq_status, edge_evt, w1c;
`endif

  assign acc         = (state == S_IDLE) && dbus2peri_i.req && gpio_sel_i;
  assign wr          = acc && dbus2peri_i.w_en;
  assign idx         = dbus2peri_i.addr[4:2];
  assign wr_val      = dbus2peri_i.w_data[GPIO_WIDTH-1:0];
  assign unused_bits = ^dbus2peri_i;

  for (genvar g = 0; g < GPIO_WIDTH; g++) begin : g_mask
    assign wr_mask[g] = dbus2peri_i.sel_byte[g/8];
  end

  always_comb begin
    rd_val = '0;
    case (idx)
      A_DATA_IN:    rd_val = 32'(sync2);
      A_DATA_OUT:   rd_val = 32'(gpio_out_o);
      A_DIR:        rd_val = 32'(gpio_oe_o);
`ifdef GPIO_IRQ_EN
      A_IRQ_EN:     rd_val = 32'(irq_en);
      A_IRQ_POL:    rd_val = 32'(irq_pol);
      A_IRQ_STATUS: rd_val = 32'(irq_status);
`endif
      default:      rd_val = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      gpio2dbus_o <= '0;
      gpio_out_o  <= '0;
      gpio_oe_o   <= '0;
`ifdef GPIO_IRQ_EN
      irq_en      <= '0;
      irq_pol     <= '0;
`endif
    end else begin
      gpio2dbus_o.ack    <= 1'b0;
      gpio2dbus_o.r_data <= '0;
      case (state)
        S_IDLE: begin
          if (acc) begin
            state              <= S_ACK;
            gpio2dbus_o.ack    <= 1'b1;
            gpio2dbus_o.r_data <= dbus2peri_i.w_en ? '0 : rd_val;
            if (wr) begin
              case (idx)
                A_DATA_OUT: gpio_out_o <= (gpio_out_o & ~wr_mask) | (wr_val & wr_mask);
                A_DIR:      gpio_oe_o  <= (gpio_oe_o & ~wr_mask) | (wr_val & wr_mask);
`ifdef GPIO_IRQ_EN
                A_IRQ_EN:   irq_en     <= (irq_en & ~wr_mask) | (wr_val & wr_mask);
                A_IRQ_POL:  irq_pol    <= (irq_pol & ~wr_mask) | (wr_val & wr_mask);
`endif
                default: ;
              endcase
            end
          end
        end
        S_ACK:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
`ifdef GPIO_IRQ_EN
      sync3 <= '0;
`endif
    end else begin
      sync1 <= gpio_in_i;
      sync2 <= sync1;
`ifdef GPIO_IRQ_EN
      sync3 <= sync2;
`endif
    end
  end

`ifdef GPIO_IRQ_EN
  assign edge_evt = (sync2 & ~sync3 & irq_pol) | (~sync2 & sync3 & ~irq_pol);
  assign w1c      = (wr && idx == A_IRQ_STATUS) ? (wr_val & wr_mask) : '0;

  // OR-ing the set term after the clear lets a same-cycle edge win over W1C.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_status <= '0;
      gpio_irq_o <= 1'b0;
    end else begin
      irq_status <= (irq_status & ~w1c) | (edge_evt & irq_en);
      gpio_irq_o <= |(irq_status & irq_en);
    end
  end
`else
  assign gpio_irq_o = 1'b0;
`endif

endmodule
